// File: rtl/reg_access_arbiter.sv
// Two-port arbiter and setup/strobe/capture sequencer in front of a small register file.
// Define REG_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.
module reg_access_arbiter #(
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 4,
  parameter logic [ADDR_W-1:0] PARK_ADDR = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_0,
  input  logic              we_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic              req_1,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              done_0,
  output logic              err_0,
  output logic [DATA_W-1:0] rdata_0,
  output logic              gnt_1,
  output logic              done_1,
  output logic              err_1,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] reg_address,
  output logic              reg_write_en,
  output logic              reg_read_en,
  output logic [DATA_W-1:0] reg_data_in,
  input  logic [DATA_W-1:0] reg_read_data
);

  localparam logic [ADDR_W-1:0] LP_NUM_REGS = ADDR_W'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_range_err;
  logic [DATA_W-1:0] r_rdata_0;
  logic [DATA_W-1:0] r_rdata_1;
  logic              w_winner;
  logic              w_active;

`ifndef REG_ARB_FIXED_PRIO_EN
  // Winner of the most recent contention; lone grants leave it untouched.
  logic              r_last_grant;
`endif

  always_comb begin
    w_winner = 1'b0;
`ifdef REG_ARB_FIXED_PRIO_EN
    w_winner = !req_0;
`else
    if (req_0 && req_1) begin
      w_winner = !r_last_grant;
    end else begin
      w_winner = !req_0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (req_0 || req_1) w_state_next = S_SETUP;
      S_SETUP:   w_state_next = S_STROBE;
      S_STROBE:  w_state_next = S_CAPTURE;
      S_CAPTURE: w_state_next = S_DONE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= PARK_ADDR;
      r_wdata     <= '0;
      r_range_err <= 1'b0;
      r_rdata_0   <= '0;
      r_rdata_1   <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
      r_last_grant <= 1'b1;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_0 || req_1) begin
            r_owner <= w_winner;
            r_we    <= w_winner ? we_1    : we_0;
            r_addr  <= w_winner ? addr_1  : addr_0;
            r_wdata <= w_winner ? wdata_1 : wdata_0;
`ifndef REG_ARB_FIXED_PRIO_EN
            if (req_0 && req_1) r_last_grant <= w_winner;
`endif
          end
        end
        S_SETUP: r_range_err <= (r_addr >= LP_NUM_REGS);
        S_CAPTURE: begin
          if (!r_we) begin
            if (r_owner) begin
              r_rdata_1 <= r_range_err ? '0 : reg_read_data;
            end else begin
              r_rdata_0 <= r_range_err ? '0 : reg_read_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes are also gated by reset so an access aborted in STROBE never reaches the register file.
  always_comb begin
    w_active     = (r_state != S_IDLE);
    gnt_0        = w_active && !r_owner;
    gnt_1        = w_active && r_owner;
    done_0       = 1'b0;
    done_1       = 1'b0;
    err_0        = 1'b0;
    err_1        = 1'b0;
    reg_address  = PARK_ADDR;
    reg_write_en = 1'b0;
    reg_read_en  = 1'b0;
    reg_data_in  = '0;
    case (r_state)
      S_SETUP: reg_address = r_addr;
      S_STROBE: begin
        reg_address = r_addr;
        if (!r_range_err && !reset) begin
          reg_write_en = r_we;
          reg_read_en  = !r_we;
          if (r_we) reg_data_in = r_wdata;
        end
      end
      S_DONE: begin
        done_0 = !r_owner;
        done_1 = r_owner;
        err_0  = !r_owner && r_range_err;
        err_1  = r_owner && r_range_err;
      end
      default: ;
    endcase
  end

  assign rdata_0 = r_rdata_0;
  assign rdata_1 = r_rdata_1;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench for reg_access_arbiter: requester tasks push expectations, a monitor pops on done.
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_0 = 1'b0, we_0 = 1'b0, req_1 = 1'b0, we_1 = 1'b0;
  logic [3:0] addr_0 = '0, addr_1 = '0;
  logic [7:0] wdata_0 = '0, wdata_1 = '0;
  logic       gnt_0, done_0, err_0, gnt_1, done_1, err_1;
  logic [7:0] rdata_0, rdata_1;
  logic [3:0] reg_address;
  logic       reg_write_en, reg_read_en;
  logic [7:0] reg_data_in;
  logic [7:0] reg_read_data = 8'h00;
  logic [7:0] rf [0:15] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                            8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};

  typedef struct packed {
    int         cyc;
    logic       we;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;

`ifdef REG_ARB_FIXED_PRIO_EN
  localparam int L2B_P0 = 4, L2B_P1 = 9;
  localparam int L5_P0_FIRST = 4, L5_P0 = 4, L5_P1_FIRST = 24, L5_P1 = 4;
`else
  localparam int L2B_P0 = 9, L2B_P1 = 4;
  localparam int L5_P0_FIRST = 4, L5_P0 = 9, L5_P1_FIRST = 9, L5_P1 = 9;
`endif

  reg_access_arbiter u_dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .done_0(done_0), .err_0(err_0), .rdata_0(rdata_0),
    .gnt_1(gnt_1), .done_1(done_1), .err_1(err_1), .rdata_1(rdata_1),
    .reg_address(reg_address), .reg_write_en(reg_write_en), .reg_read_en(reg_read_en),
    .reg_data_in(reg_data_in), .reg_read_data(reg_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file model: write on strobe, read data registered and valid during CAPTURE.
  always @(posedge clk) begin
    if (reg_write_en) rf[reg_address] <= reg_data_in;
    if (reg_read_en) reg_read_data <= rf[reg_address];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int p, input logic d, input logic e, input logic [7:0] rd);
    exp_t x;
    if (!d) begin
      chk($sformatf("err_%0d_without_done", p), e, 0);
    end else if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_%0d_unexpected: got done at cycle %0d, expected none", p, cyc);
    end else begin
      x = (p == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("done_%0d_cycle", p), cyc, x.cyc);
      chk($sformatf("err_%0d", p), e, x.err);
      if (!x.we) chk($sformatf("rdata_%0d", p), rd, x.rd);
      $display("port %0d %s done at cycle %0d err=%0d rdata=0x%02h", p, x.we ? "write" : "read",
               cyc, e, rd);
    end
  endtask

  // Monitor: protocol invariants every cycle plus scoreboard pops on done.
  initial begin
    logic       prev_strobe;
    logic [3:0] prev_addr;
    prev_strobe = 1'b0;
    prev_addr   = 4'hF;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_strobe = 1'b0;
      end else begin
        chk("gnt_exclusive", int'(gnt_0 && gnt_1), 0);
        chk("strobe_exclusive", int'(reg_write_en && reg_read_en), 0);
        chk("strobe_single_cycle", int'(prev_strobe && (reg_write_en || reg_read_en)), 0);
        if (!gnt_0 && !gnt_1) chk("idle_park_addr", reg_address, 4'hF);
        if (reg_write_en || reg_read_en) begin
          chk("strobe_needs_gnt", int'(gnt_0 || gnt_1), 1);
          chk("addr_setup_stable", reg_address, prev_addr);
        end
        if (reg_write_en) wr_cnt++;
        if (reg_read_en) rd_cnt++;
        prev_strobe = reg_write_en || reg_read_en;
        check_done(0, done_0, err_0, rdata_0);
        check_done(1, done_1, err_1, rdata_1);
      end
      prev_addr = reg_address;
    end
  end

  // One complete access on port p; called just after a rising edge, returns just after one.
  task automatic access(input int p, input logic we, input logic [3:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    logic got;
    e.cyc = cyc + lat;
    e.we  = we;
    e.rd  = exp_rd;
    e.err = exp_err;
    if (p == 0) begin
      q0.push_back(e);
      req_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = wd;
    end else begin
      q1.push_back(e);
      req_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = wd;
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      got = (p == 0) ? done_0 : done_1;
      n++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout port %0d: no done after %0d cycles, expected after %0d", p, n, lat);
    end
    @(posedge clk);
    #1;
    if (p == 0) req_0 = 1'b0;
    else        req_1 = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_vals [0:3];
    int         wr_save, rd_save;
    exp_vals[0] = 8'hA5; exp_vals[1] = 8'hA6; exp_vals[2] = 8'hA7; exp_vals[3] = 8'h13;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_gnt", {gnt_0, gnt_1}, 0);
    chk("rst_done_err", {done_0, done_1, err_0, err_1}, 0);
    chk("rst_strobes", {reg_write_en, reg_read_en}, 0);
    chk("rst_reg_address", reg_address, 4'hF);
    chk("rst_reg_data_in", reg_data_in, 0);
    chk("rst_rdata", {rdata_0, rdata_1}, 0);
    @(posedge clk);
    #1;

    // Single port write then read back.
    access(0, 1'b1, 4'd0, 8'hA5, 8'h00, 1'b0, 4);
    access(0, 1'b0, 4'd0, 8'h00, 8'hA5, 1'b0, 4);
    chk("t1_write_strobes", wr_cnt, 1);
    chk("t1_read_strobes", rd_cnt, 1);

    // Simultaneous writes, then simultaneous reads back.
    fork
      access(0, 1'b1, 4'd1, 8'hA6, 8'h00, 1'b0, 4);
      access(1, 1'b1, 4'd2, 8'hA7, 8'h00, 1'b0, 9);
    join
    fork
      access(0, 1'b0, 4'd1, 8'h00, 8'hA6, 1'b0, L2B_P0);
      access(1, 1'b0, 4'd2, 8'h00, 8'hA7, 1'b0, L2B_P1);
    join
    chk("t2_write_strobes", wr_cnt, 3);
    chk("t2_read_strobes", rd_cnt, 3);

    // Out-of-range read: no strobe, error with zero data.
    wr_save = wr_cnt;
    rd_save = rd_cnt;
    access(1, 1'b0, 4'h9, 8'h00, 8'h00, 1'b1, 4);
    chk("t3_no_write_strobe", wr_cnt, wr_save);
    chk("t3_no_read_strobe", rd_cnt, rd_save);

    // Reset in the STROBE cycle of a write to addr 3 aborts it.
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 4'd3; wdata_0 = 8'hA8;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_0 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t4_gnt", {gnt_0, gnt_1}, 0);
    chk("t4_done", {done_0, done_1}, 0);
    chk("t4_strobes", {reg_write_en, reg_read_en}, 0);
    chk("t4_reg_address", reg_address, 4'hF);
    chk("t4_reg_data_in", reg_data_in, 0);
    chk("t4_rdata", {rdata_0, rdata_1}, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    access(1, 1'b0, 4'd3, 8'h00, 8'h13, 1'b0, 4);

    // Both ports hold requests continuously, reading addrs 0..3.
    fork
      begin
        for (int i = 0; i < 4; i++)
          access(0, 1'b0, 4'(i), 8'h00, exp_vals[i], 1'b0, (i == 0) ? L5_P0_FIRST : L5_P0);
      end
      begin
        for (int j = 0; j < 4; j++)
          access(1, 1'b0, 4'(j), 8'h00, exp_vals[j], 1'b0, (j == 0) ? L5_P1_FIRST : L5_P1);
      end
    join

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Two-port arbiter and access sequencer in front of the 4-register device register file. It accepts single read/write requests from two independent requesters, grants one at a time, and drives the register file with its address-setup / one-cycle-strobe / capture protocol. Read data and completion are returned to the owning requester, and out-of-range addresses are rejected without touching the register file.

## Interface
- ADDR_W, 4, address width of register file and requesters
- DATA_W, 8, data width
- NUM_REGS, 4, implemented registers; valid addresses 0..NUM_REGS-1 (NUM_REGS ≤ 15)
- PARK_ADDR, 4'hF, address driven to the register file whenever no access is in flight
- clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_0 / req_1  in  1  access request; held with fields stable until matching done_x
- we_0 / we_1  in  1  1 = write, 0 = read
- addr_0 / addr_1  in  ADDR_W  target register
- wdata_0 / wdata_1  in  DATA_W  write data
- gnt_0 / gnt_1  out  1  high while that port owns the register file
- done_0 / done_1  out  1  one-cycle completion pulse
- err_0 / err_1  out  1  one-cycle pulse with done_x when the address was out of range
- rdata_0 / rdata_1  out  DATA_W  read result, valid with done_x, held until that port's next read completes
- reg_address  out  ADDR_W  to register file address
- reg_write_en  out  1  to register file write_en
- reg_read_en  out  1  to register file read_en
- reg_data_in  out  DATA_W  to register file data_in
- reg_read_data  in  DATA_W  from register file read_data

## Operation
- FSM: IDLE, SETUP, STROBE, CAPTURE, DONE.
- IDLE: if any req_x is high, select the winner, latch its we/addr/wdata into internal registers, go to SETUP. Otherwise stay in IDLE.
- SETUP: drive reg_address = latched addr. Strobes stay low. If the address is ≥ NUM_REGS, set the internal range error and skip the strobe.
- STROBE: assert reg_write_en (with reg_data_in = latched wdata) or reg_read_en for exactly one cycle. Both are suppressed on a range error.
- CAPTURE: strobes low, reg_address = PARK_ADDR, reg_data_in = 0. At the end of this cycle, a read samples reg_read_data into rdata_x. A read with a range error loads 0 instead.
- DONE: pulse done_x, plus err_x on range error, for the owner. gnt_x drops at the end of DONE. Next state is IDLE.
- Arbitration: round-robin. A last_grant bit records the previous winner. When both ports request, the other port wins. After reset last_grant = 1, so port 0 wins the first contention. A lone requester always wins.
- Writes traverse CAPTURE too, giving uniform latency.
- Reset values: state IDLE; gnt_x, done_x, err_x, reg_write_en, reg_read_en = 0; reg_address = PARK_ADDR; reg_data_in = 0; rdata_x = 0; last_grant = 1.
- Reset asserted mid-access aborts it. No strobe and no done are issued afterward. The requester must re-request.
- req_x dropped before done_x is a protocol violation. The access still completes and done_x still pulses.

## Timing
- Cycle 0: IDLE samples req_x.
- Cycle 1: SETUP, gnt_x high.
- Cycle 2: STROBE.
- Cycle 3: CAPTURE.
- Cycle 4: DONE, done_x high, rdata_x valid.
- Latency from req sampled to done_x is 4 cycles. Minimum spacing between accesses is 5 cycles.
- reg_address is stable for at least one full cycle before and during the strobe.
- Exactly one of reg_write_en / reg_read_en is ever high, and never for more than one cycle per access.
- If the loser's request is still high in the IDLE after DONE, it is granted immediately.

## Configuration
- REG_ARB_FIXED_PRIO_EN defined: fixed priority. Port 0 always wins contention and last_grant is unused.
- Not defined: round-robin as described above.

## Test plan
- Port 0 writes 8'hA5 to addr 0, then reads addr 0 → done_0 at cycle 4 each time; rdata_0 = 8'hA5; err_0 = 0; one-cycle reg_write_en then one-cycle reg_read_en.
- Port 0 and port 1 request in the same cycle (write 8'hA6 to addr 1 and write 8'hA7 to addr 2) → port 0 is served first, port 1 next with done_1 five cycles after done_0. Port 0 and port 1 then re-request simultaneously and port 1 wins (round-robin). With REG_ARB_FIXED_PRIO_EN, port 0 wins both times.
- Port 1 reads addr 4'h9 → no strobe asserted; done_1 and err_1 pulse together; rdata_1 = 8'h00.
- Reset asserted during STROBE of a write of 8'hA8 to addr 3 → outputs return to reset values next cycle; no done; a later read of addr 3 returns the pre-reset register-file value.
- Both ports hold req continuously with alternating reads of addrs 0..3 → strict alternation; gnt_0 and gnt_1 are never high together; reg_address = 4'hF in every IDLE cycle.
